// File: rtl/rm_ihpsg13_sram_pkg.sv
// Shared types and helpers for the IHP SG13G2 SRAM front-end controllers.
package rm_ihpsg13_sram_pkg;

  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_BE_W   = MAX_DATA_W / 8;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  // Bank-select field width; a single bank still carries a 1-bit field.
  function automatic int unsigned bsel_w(input int unsigned num_banks);
    return (num_banks <= 1) ? 32'd1 : 32'($clog2(num_banks));
  endfunction

  // Per byte: take new_word where be is set, otherwise keep old_word.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] old_word,
    input logic [MAX_DATA_W-1:0] new_word,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] m;
    m = old_word;
    for (int i = 0; i < int'(MAX_BE_W); i++) begin
      if (be[i]) m[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/rm_ihpsg13_1p_banked_ctrl_if.sv
// SoC-side req/gnt/rvalid memory port of the banked single-port SRAM controller.
interface rm_ihpsg13_1p_banked_ctrl_if
  import rm_ihpsg13_sram_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BANK_AW   = 13,
  parameter int unsigned NUM_BANKS = 2
);
  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned AW   = BANK_AW + bsel_w(NUM_BANKS);

  logic              A_REQ;
  logic              A_GNT;
  logic              A_WE;
  logic [BE_W-1:0]   A_BE;
  logic [AW-1:0]     A_ADDR;
  logic [DATA_W-1:0] A_WDATA;
  logic              A_RVALID;
  logic [DATA_W-1:0] A_RDATA;
  logic              A_ERR;

  modport master (
    output A_REQ, A_WE, A_BE, A_ADDR, A_WDATA,
    input  A_GNT, A_RVALID, A_RDATA, A_ERR
  );

  modport slave (
    input  A_REQ, A_WE, A_BE, A_ADDR, A_WDATA,
    output A_GNT, A_RVALID, A_RDATA, A_ERR
  );
endinterface

// File: rtl/rm_ihpsg13_1p_banked_ctrl.sv
// Front-end for NUM_BANKS single-port SG13G2 SRAM macros: handshake, bank decode,
// and byte-enable writes via an internal read-modify-write.
module rm_ihpsg13_1p_banked_ctrl
  import rm_ihpsg13_sram_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BANK_AW   = 13,
  parameter int unsigned NUM_BANKS = 2
) (
  input  logic                          A_CLK,
  input  logic                          A_RST,
  rm_ihpsg13_1p_banked_ctrl_if.slave    a_if,
  output logic [NUM_BANKS-1:0]          M_MEN,
  output logic [NUM_BANKS-1:0]          M_WEN,
  output logic [NUM_BANKS-1:0]          M_REN,
  output logic [BANK_AW-1:0]            M_ADDR,
  output logic [DATA_W-1:0]             M_DIN,
  output logic                          M_DLY,
  input  logic [NUM_BANKS*DATA_W-1:0]   M_DOUT
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned BSEL_W = bsel_w(NUM_BANKS);
  localparam int unsigned AW     = BANK_AW + BSEL_W;

  state_e              state_q, state_d;
  logic [BSEL_W-1:0]   req_bank, bank_q, rd_bank_q;
  logic [BANK_AW-1:0]  req_row, row_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [NUM_BANKS-1:0] req_sel, merge_sel;
  logic [DATA_W-1:0]   merge_old, rd_word;
  logic                bank_hit, be_full, be_zero, gnt;
  logic                rvalid_q, err_q, rd_q;

  assign req_bank = a_if.A_ADDR[AW-1:BANK_AW];
  assign req_row  = a_if.A_ADDR[BANK_AW-1:0];
  assign be_full  = &a_if.A_BE;
  assign be_zero  = ~|a_if.A_BE;
  assign bank_hit = |req_sel;
  assign M_DLY    = 1'b1;

  // Bank decode and read-data steering; out-of-range banks select nothing.
  always_comb begin
    req_sel   = '0;
    merge_sel = '0;
    merge_old = '0;
    rd_word   = '0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      req_sel[b]   = (req_bank == BSEL_W'(b));
      merge_sel[b] = (bank_q == BSEL_W'(b));
      if (bank_q == BSEL_W'(b))    merge_old = M_DOUT[b*DATA_W +: DATA_W];
      if (rd_bank_q == BSEL_W'(b)) rd_word   = M_DOUT[b*DATA_W +: DATA_W];
    end
  end

  // Next state and macro strobes; MERGE blocks new grants for one cycle.
  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    M_MEN   = '0;
    M_WEN   = '0;
    M_REN   = '0;
    M_ADDR  = req_row;
    M_DIN   = a_if.A_WDATA;
    case (state_q)
      IDLE: begin
        gnt = a_if.A_REQ && !A_RST;
        if (gnt && bank_hit) begin
          if (!a_if.A_WE) begin
            M_MEN = req_sel;
            M_REN = req_sel;
          end else if (be_full) begin
            M_MEN = req_sel;
            M_WEN = req_sel;
          end else if (!be_zero) begin
            M_MEN   = req_sel;
            M_REN   = req_sel;
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        state_d = IDLE;
        M_ADDR  = row_q;
        M_DIN   = DATA_W'(byte_merge(MAX_DATA_W'(merge_old), MAX_DATA_W'(wdata_q),
                                     MAX_BE_W'(be_q)));
        if (!A_RST) begin
          M_MEN = merge_sel;
          M_WEN = merge_sel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured write context and response registers.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      state_q   <= IDLE;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      rd_bank_q <= '0;
      bank_q    <= '0;
      row_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rvalid_q  <= (gnt && (state_d == IDLE)) || (state_q == MERGE);
      err_q     <= gnt && !bank_hit;
      rd_q      <= gnt && !a_if.A_WE && bank_hit;
      rd_bank_q <= req_bank;
      if (gnt) begin
        bank_q  <= req_bank;
        row_q   <= req_row;
        be_q    <= a_if.A_BE;
        wdata_q <= a_if.A_WDATA;
      end
    end
  end

  assign a_if.A_GNT    = gnt;
  assign a_if.A_RVALID = rvalid_q;
  assign a_if.A_ERR    = rvalid_q && err_q;
  assign a_if.A_RDATA  = (rvalid_q && rd_q) ? rd_word : '0;

endmodule
